mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Synchronous, parametrised successor to the team's 3-bit ripple up-counter.
- Single clock domain; no clock derived from flop outputs.
- Configurable width and modulus; up, down and bounce (up/down ping-pong) modes; parallel load; terminal-count and wrap flags.
- Used as a generic event/tick counter and timebase in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- MODULUS, 0, count range: 0 means full 2**WIDTH; otherwise 2..2**WIDTH. Elaboration error outside this range.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- mode  input  2  00 = up, 01 = down, 10 = bounce, 11 = reserved (hold).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value for load.
- q  output  WIDTH  registered count.
- q_not  output  WIDTH  bitwise ~q, combinational.
- dir  output  1  registered direction; 1 = counting up.
- tc  output  1  combinational terminal count; see Behaviour.
- wrap  output  1  registered one-cycle pulse on wrap or reversal.

Behaviour:
- MAX = MODULUS-1, or 2**WIDTH-1 when MODULUS=0. q is always within 0..MAX.
- Priority per edge: rst > load > en. en low and no load: q, dir hold; wrap = 0.
- Reset values: rst high at a clk edge gives q=0, dir=1, wrap=0. Takes effect only at the edge; a mid-count reset aborts the count on that edge.
- Load:
  - q <= load_val, clamped to MAX if load_val > MAX.
  - wrap = 0; dir unchanged, except that in up/down modes dir follows mode as below.
  - Load beats en on the same edge.
- Up (00), en=1:
  - q <= q+1.
  - At q==MAX: q <= 0 and wrap=1 next cycle. dir <= 1.
- Down (01), en=1:
  - q <= q-1.
  - At q==0: q <= MAX and wrap=1. dir <= 0.
- dir in up/down modes is rewritten every cycle from mode, whether or not en is high.
- Bounce (10), en=1:
  - dir=1, q<MAX: q+1.
  - dir=1, q==MAX: q <= MAX-1, dir <= 0, wrap=1.
  - dir=0, q>0: q-1.
  - dir=0, q==0: q <= 1, dir <= 1, wrap=1.
  - Endpoints appear once per sweep: 0,1,..,MAX,MAX-1,..,1,0,1,...
  - Entering bounce keeps the current dir.
- Reserved (11): q, dir hold; wrap = 0; load still honoured.
- Mode change takes effect on the same edge it is sampled.
- tc = en & one of:
  - q==MAX in up mode,
  - q==0 in down mode,
  - q==(dir ? MAX : 0) in bounce mode.
  - tc = 0 in reserved mode.
  - tc is valid in the cycle before wrap.
- wrap is high for exactly one cycle per wrap or reversal event, and is cleared by any load or reset.
- All arithmetic is WIDTH bits wide, with the compare against MAX done before increment/decrement. There is no transient out-of-range value.

Optional Feature:
- Macro: MOD_UPDOWN_COUNTER_GRAY_EN.
- Defined:
  - Adds output port q_gray, WIDTH bits, equal to q ^ (q >> 1), combinational from q.
  - Meaningful as a single-bit-change code only when MODULUS=0 in up/down modes; bounce mode is also single-step.
- Undefined: port q_gray is absent; all other behaviour is identical.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset then up count: rst=1 for 2 cycles, then en=1, mode=00 for 12 cycles -> q = 0,1,..,9,0,1; tc=1 only while q=9; wrap=1 exactly in the cycle q=0 after 9; q_not=~q throughout.
- Down wrap: load load_val=2, mode=01, en=1 -> q = 2,1,0,9,8; wrap=1 in the cycle q=9; dir=0.
- Bounce: mode=10 from reset, en=1 for 20 cycles -> q = 0..9,8,..,0,1; wrap pulses at q=8 (after 9) and at q=1 (after 0); dir flips at the same edges.
- Load priority and clamp: load=1, en=1, load_val=13 in the same cycle -> q=9 (clamped), wrap=0; next enabled up step -> q=0, wrap=1.
- Synchronous reset mid-count: q=6, mode=10, dir=0, assert rst for one edge with en=1 and load=1 -> q=0, dir=1, wrap=0 next cycle; no change before the edge.
- MODULUS=0, MOD_UPDOWN_COUNTER_GRAY_EN defined: up count 15 -> 0 -> q_gray 1000 -> 0000, wrap=1; every step changes exactly one q_gray bit.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous up/down/bounce counter with a configurable
// width and modulus. It supports parallel load, a combinational terminal-count
// output and a registered wrap/reversal pulse.
// Optional build macro: MOD_UPDOWN_COUNTER_GRAY_EN adds a combinational q_gray output.
module mod_updown_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             dir,
    output logic             tc,
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic             wrap
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam longint unsigned FULL_RANGE = 64'd1 << WIDTH;

    // Largest value q may hold; MODULUS of zero selects the full binary range.
    localparam logic [WIDTH-1:0] MAX = (MODULUS == 64'd0) ? {WIDTH{1'b1}}
                                                          : WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be within 2..32");
    end

    if (MODULUS == 64'd1 || MODULUS > FULL_RANGE) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be 0 or within 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q_nxt;
    logic             dir_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX);
    assign at_zero = (q == '0);

    // State register: reset is sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            dir  <= 1'b1;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            dir  <= dir_nxt;
            wrap <= wrap_nxt;
        end
    end

    // Next-state logic: load beats count; endpoints are tested before stepping, so q never leaves 0..MAX.
    always_comb begin
        q_nxt    = q;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = (load_val > MAX) ? MAX : load_val;
            if (mode == MODE_UP) begin
                dir_nxt = 1'b1;
            end else if (mode == MODE_DOWN) begin
                dir_nxt = 1'b0;
            end
        end else begin
            case (mode)
                MODE_UP: begin
                    dir_nxt = 1'b1;
                    if (en) begin
                        if (at_max) begin
                            q_nxt    = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            q_nxt = q + WIDTH'(1);
                        end
                    end
                end
                MODE_DOWN: begin
                    dir_nxt = 1'b0;
                    if (en) begin
                        if (at_zero) begin
                            q_nxt    = MAX;
                            wrap_nxt = 1'b1;
                        end else begin
                            q_nxt = q - WIDTH'(1);
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (en) begin
                        if (dir) begin
                            if (at_max) begin
                                q_nxt    = MAX - WIDTH'(1);
                                dir_nxt  = 1'b0;
                                wrap_nxt = 1'b1;
                            end else begin
                                q_nxt = q + WIDTH'(1);
                            end
                        end else begin
                            if (at_zero) begin
                                q_nxt    = WIDTH'(1);
                                dir_nxt  = 1'b1;
                                wrap_nxt = 1'b1;
                            end else begin
                                q_nxt = q - WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    q_nxt = q;
                end
            endcase
        end
    end

    // Terminal count: high on the enabled cycle that precedes a wrap or reversal.
    always_comb begin
        tc = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP:     tc = at_max;
                MODE_DOWN:   tc = at_zero;
                MODE_BOUNCE: tc = dir ? at_max : at_zero;
                default:     tc = 1'b0;
            endcase
        end
    end

    assign q_not = ~q;

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    assign q_gray = q ^ (q >> 1);
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Testbench for mod_updown_counter: a MODULUS=10 instance and a full-range instance share the stimulus.
module tb_mod_updown_counter;

    localparam int unsigned W = 4;
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef struct packed {
        logic [W-1:0] q;
        logic         dir;
        logic         wrap;
    } exp_t;

    typedef struct packed {
        logic         rst;
        logic         en;
        logic [1:0]   mode;
        logic         load;
        logic [W-1:0] lv;
        logic         tc;
        logic [W-1:0] q;
        logic         dir;
        logic         wrap;
    } step_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q, q_not, q2, q2_not;
    logic         dir, tc, wrap, dir2, tc2, wrap2;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    logic [W-1:0] q_gray, q2_gray;
`endif

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .q(q), .q_not(q_not), .dir(dir), .tc(tc),
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        .q_gray(q_gray),
`endif
        .wrap(wrap)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .q(q2), .q_not(q2_not), .dir(dir2), .tc(tc2),
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        .q_gray(q2_gray),
`endif
        .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic l, input logic [W-1:0] lv);
        rst = r; en = e; mode = m; load = l; load_val = lv;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, MODE_UP, 1'b0, 4'd0);
            e.q = 4'd0; e.dir = 1'b1; e.wrap = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || dir !== e.dir || wrap !== e.wrap || q_not !== ~e.q) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got q=%0d dir=%b wrap=%b q_not=%h, exp q=%0d dir=%b wrap=%b", i, q, dir, wrap, q_not, e.q, e.dir, e.wrap);
            end
            n_tests++;
            if (q2 !== e.q || dir2 !== e.dir || wrap2 !== e.wrap) begin
                n_fail++;
                $display("FAIL reset_full cyc %0d: got q=%0d dir=%b wrap=%b, exp q=%0d dir=%b wrap=%b", i, q2, dir2, wrap2, e.q, e.dir, e.wrap);
            end
        end
    endtask

    task automatic test_up();
        exp_t e;
        int   cur;
        logic exp_tc;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, MODE_UP, 1'b0, 4'd0);
            #1;
            exp_tc = (cur == 9);
            n_tests++;
            if (tc !== exp_tc) begin
                n_fail++;
                $display("FAIL up_tc step %0d: got %b exp %b", i, tc, exp_tc);
            end
            e.q = 4'((cur + 1) % 10); e.dir = 1'b1; e.wrap = (cur == 9);
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || dir !== e.dir || wrap !== e.wrap || q_not !== ~e.q) begin
                n_fail++;
                $display("FAIL up_out step %0d: got q=%0d dir=%b wrap=%b q_not=%h, exp q=%0d dir=%b wrap=%b", i, q, dir, wrap, q_not, e.q, e.dir, e.wrap);
            end
            cur = (cur + 1) % 10;
        end
    endtask

    task automatic test_down();
        step_t        t [5];
        exp_t         e;
        logic [W-1:0] prev_q;
        t = '{
            '{1'b0, 1'b1, MODE_DOWN, 1'b1, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0},
            '{1'b0, 1'b1, MODE_DOWN, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, MODE_DOWN, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0},
            '{1'b0, 1'b1, MODE_DOWN, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1},
            '{1'b0, 1'b1, MODE_DOWN, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 1'b0}
        };
        prev_q = 4'd2;
        for (int i = 0; i < 5; i++) begin
            drive(t[i].rst, t[i].en, t[i].mode, t[i].load, t[i].lv);
            #1;
            n_tests++;
            if (tc !== t[i].tc || q !== prev_q) begin
                n_fail++;
                $display("FAIL down_pre step %0d: got tc=%b q=%0d, exp tc=%b q=%0d", i, tc, q, t[i].tc, prev_q);
            end
            e.q = t[i].q; e.dir = t[i].dir; e.wrap = t[i].wrap;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || dir !== e.dir || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL down_out step %0d: got q=%0d dir=%b wrap=%b, exp q=%0d dir=%b wrap=%b", i, q, dir, wrap, e.q, e.dir, e.wrap);
            end
            prev_q = e.q;
        end
    endtask

    task automatic test_bounce();
        exp_t         e;
        int           bq [20];
        logic [W-1:0] cur_q;
        logic         cur_dir;
        logic         exp_tc;
        bq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        drive(1'b1, 1'b0, MODE_BOUNCE, 1'b0, 4'd0);
        @(posedge clk); #1;
        n_tests++;
        if (q !== 4'd0 || dir !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_reset: got q=%0d dir=%b wrap=%b, exp q=0 dir=1 wrap=0", q, dir, wrap);
        end
        cur_q = 4'd0; cur_dir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, MODE_BOUNCE, 1'b0, 4'd0);
            #1;
            exp_tc = cur_dir ? (cur_q == 4'd9) : (cur_q == 4'd0);
            n_tests++;
            if (tc !== exp_tc) begin
                n_fail++;
                $display("FAIL bounce_tc step %0d: got %b exp %b", i, tc, exp_tc);
            end
            e.q = 4'(bq[i]); e.dir = (i < 9) || (i >= 18); e.wrap = (i == 9) || (i == 18);
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || dir !== e.dir || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL bounce_out step %0d: got q=%0d dir=%b wrap=%b, exp q=%0d dir=%b wrap=%b", i, q, dir, wrap, e.q, e.dir, e.wrap);
            end
            cur_q = e.q; cur_dir = e.dir;
        end
    endtask

    task automatic test_load_clamp();
        step_t        t [6];
        exp_t         e;
        logic [W-1:0] prev_q;
        t = '{
            '{1'b0, 1'b1, MODE_UP,   1'b1, 4'd13, 1'b0, 4'd9, 1'b1, 1'b0},
            '{1'b0, 1'b1, MODE_UP,   1'b1, 4'd9,  1'b1, 4'd9, 1'b1, 1'b0},
            '{1'b0, 1'b1, MODE_UP,   1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 1'b1},
            '{1'b0, 1'b0, MODE_UP,   1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b0},
            '{1'b0, 1'b1, MODE_HOLD, 1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b0},
            '{1'b0, 1'b1, MODE_HOLD, 1'b1, 4'd5,  1'b0, 4'd5, 1'b1, 1'b0}
        };
        prev_q = 4'd2;
        for (int i = 0; i < 6; i++) begin
            drive(t[i].rst, t[i].en, t[i].mode, t[i].load, t[i].lv);
            #1;
            n_tests++;
            if (tc !== t[i].tc || q !== prev_q) begin
                n_fail++;
                $display("FAIL load_pre step %0d: got tc=%b q=%0d, exp tc=%b q=%0d", i, tc, q, t[i].tc, prev_q);
            end
            e.q = t[i].q; e.dir = t[i].dir; e.wrap = t[i].wrap;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || dir !== e.dir || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL load_out step %0d: got q=%0d dir=%b wrap=%b, exp q=%0d dir=%b wrap=%b", i, q, dir, wrap, e.q, e.dir, e.wrap);
            end
            prev_q = e.q;
        end
    endtask

    task automatic test_mid_reset();
        step_t        t [3];
        exp_t         e;
        logic [W-1:0] prev_q;
        t = '{
            '{1'b0, 1'b1, MODE_DOWN,   1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0},
            '{1'b0, 1'b1, MODE_BOUNCE, 1'b0, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0},
            '{1'b1, 1'b1, MODE_BOUNCE, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0}
        };
        prev_q = 4'd5;
        for (int i = 0; i < 3; i++) begin
            drive(t[i].rst, t[i].en, t[i].mode, t[i].load, t[i].lv);
            #1;
            n_tests++;
            if (tc !== t[i].tc || q !== prev_q) begin
                n_fail++;
                $display("FAIL midrst_pre step %0d: got tc=%b q=%0d, exp tc=%b q=%0d", i, tc, q, t[i].tc, prev_q);
            end
            e.q = t[i].q; e.dir = t[i].dir; e.wrap = t[i].wrap;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || dir !== e.dir || wrap !== e.wrap) begin
                n_fail++;
                $display("FAIL midrst_out step %0d: got q=%0d dir=%b wrap=%b, exp q=%0d dir=%b wrap=%b", i, q, dir, wrap, e.q, e.dir, e.wrap);
            end
            prev_q = e.q;
        end
    endtask

    task automatic test_full_range();
        exp_t         e;
        int           cur;
        logic         exp_tc;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        logic [W-1:0] prev_gray;
`endif
        drive(1'b1, 1'b0, MODE_UP, 1'b0, 4'd0);
        @(posedge clk); #1;
        n_tests++;
        if (q2 !== 4'd0 || dir2 !== 1'b1 || wrap2 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_reset: got q=%0d dir=%b wrap=%b, exp q=0 dir=1 wrap=0", q2, dir2, wrap2);
        end
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        prev_gray = 4'b0000;
`endif
        cur = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, MODE_UP, 1'b0, 4'd0);
            #1;
            exp_tc = (cur == 15);
            n_tests++;
            if (tc2 !== exp_tc) begin
                n_fail++;
                $display("FAIL full_tc step %0d: got %b exp %b", i, tc2, exp_tc);
            end
            e.q = 4'((cur + 1) % 16); e.dir = 1'b1; e.wrap = (cur == 15);
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (q2 !== e.q || dir2 !== e.dir || wrap2 !== e.wrap || q2_not !== ~e.q) begin
                n_fail++;
                $display("FAIL full_out step %0d: got q=%0d dir=%b wrap=%b q_not=%h, exp q=%0d dir=%b wrap=%b", i, q2, dir2, wrap2, q2_not, e.q, e.dir, e.wrap);
            end
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
            n_tests++;
            if ($countones(q2_gray ^ prev_gray) != 1) begin
                n_fail++;
                $display("FAIL gray_step step %0d: got %b after %b, exp exactly one bit change", i, q2_gray, prev_gray);
            end
            if (e.q == 4'd15) begin
                n_tests++;
                if (q2_gray !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL gray_15: got %b exp 1000", q2_gray);
                end
            end
            if (e.q == 4'd0) begin
                n_tests++;
                if (q2_gray !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL gray_0: got %b exp 0000", q2_gray);
                end
            end
            prev_gray = q2_gray;
`endif
            cur = (cur + 1) % 16;
        end
        drive(1'b0, 1'b1, MODE_DOWN, 1'b0, 4'd0);
        #1;
        n_tests++;
        if (tc2 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_down_tc: got %b exp 1", tc2);
        end
        e.q = 4'd15; e.dir = 1'b0; e.wrap = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (q2 !== e.q || dir2 !== e.dir || wrap2 !== e.wrap) begin
            n_fail++;
            $display("FAIL full_down_out: got q=%0d dir=%b wrap=%b, exp q=%0d dir=%b wrap=%b", q2, dir2, wrap2, e.q, e.dir, e.wrap);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, MODE_UP, 1'b0, 4'd0);
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_load_clamp();
        test_mid_reset();
        test_full_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
